// File: rtl/parking_pkg.sv
// Shared gate/entry definitions: actuator state encoding and
// default travel limits used by the gate actuator and entry controller.
package parking_pkg;

    localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd1000;
    localparam logic [1:0]  MAX_RETRY_DEF   = 2'd3;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } gate_state_t;

    function automatic logic in_motion(input gate_state_t s);
        return (s == ST_OPENING) || (s == ST_CLOSING);
    endfunction

endpackage

// File: rtl/travel_timer.sv
// Motor-on cycle counter with synchronous clear, count enable
// and a terminal-count flag at TC-1 (last allowed motor cycle).
module travel_timer #(
    parameter logic [15:0] TC = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 16'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tc = (r_cnt == (TC - 16'd1));

endmodule

// File: rtl/gate_actuator.sv
// Parking barrier actuator: open/close sequencing with limit switches,
// obstruction reversal with retry limit, travel timeout and fault lockout.
module gate_actuator
    import parking_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [1:0]  MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       open_cmd,
    input  logic       close_cmd,
    input  logic       lim_open,
    input  logic       lim_closed,
    input  logic       obstruct,
    input  logic       fault_clr,
    output logic       motor_up,
    output logic       motor_down,
    output logic       gate_open,
    output logic       gate_closed,
    output logic       busy,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    gate_state_t r_state;
    gate_state_t w_next;
    logic [1:0]  r_retry;
    logic [1:0]  w_retry_nxt;
    logic        r_pending;
    logic        w_pend_nxt;
    logic        w_pend_eff;
    logic [2:0]  w_retry_inc;
    logic        w_retry_max;
    logic        w_tc;
    logic        w_tmr_clr;
    logic        w_tmr_en;

    // open_cmd cancels any close request, including one arriving this cycle
    assign w_pend_eff  = !open_cmd && (close_cmd || r_pending);
    assign w_retry_inc = {1'b0, r_retry} + 3'd1;
    assign w_retry_max = (w_retry_inc == {1'b0, MAX_RETRY});

    assign w_tmr_clr = (w_next != r_state);
    assign w_tmr_en  = in_motion(r_state);

    travel_timer #(
        .TC (TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_next      = r_state;
        w_retry_nxt = r_retry;
        w_pend_nxt  = 1'b0;
        if (r_state != ST_FAULT && lim_open && lim_closed) begin
            w_next = ST_FAULT;
        end else begin
            unique case (r_state)
                ST_CLOSED: begin
                    if (open_cmd) begin
                        w_next = ST_OPENING;
                    end else if (!lim_closed) begin
                        w_next = ST_CLOSING;
                    end
                end
                ST_OPENING: begin
                    if (lim_open) begin
                        w_next = ST_OPEN;
                    end else if (w_tc) begin
                        w_next = ST_FAULT;
                    end
                end
                ST_OPEN: begin
                    if (w_pend_eff && !obstruct) begin
                        w_next = ST_CLOSING;
                    end else begin
                        w_pend_nxt = w_pend_eff;
                    end
                end
                ST_CLOSING: begin
                    if (lim_closed) begin
                        w_next      = ST_CLOSED;
                        w_retry_nxt = 2'd0;
                    end else if (w_tc) begin
                        w_next = ST_FAULT;
                    end else if (open_cmd) begin
                        w_next = ST_OPENING;
                    end else if (obstruct) begin
                        if (w_retry_max) begin
                            w_next = ST_FAULT;
                        end else begin
                            w_next      = ST_OPENING;
                            w_retry_nxt = w_retry_inc[1:0];
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        w_next      = ST_CLOSING;
                        w_retry_nxt = 2'd0;
                    end
                end
                default: begin
                    w_next = ST_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLOSED;
            r_retry   <= 2'd0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_retry   <= w_retry_nxt;
            r_pending <= w_pend_nxt;
        end
    end

    assign motor_up    = (r_state == ST_OPENING);
    assign motor_down  = (r_state == ST_CLOSING);
    assign gate_open   = (r_state == ST_OPEN);
    assign gate_closed = (r_state == ST_CLOSED);
    assign busy        = in_motion(r_state);
    assign fault       = (r_state == ST_FAULT);
    assign retry_cnt   = r_retry;

endmodule

// File: tb/tb_gate_actuator.sv
// Directed bench for gate_actuator with a cycle-level reference model
// compared on every falling edge, plus literal spot checks.
module tb_gate_actuator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       open_cmd = 1'b0;
    logic       close_cmd = 1'b0;
    logic       lim_open = 1'b0;
    logic       lim_closed = 1'b1;
    logic       obstruct = 1'b0;
    logic       fault_clr = 1'b0;
    logic       motor_up;
    logic       motor_down;
    logic       gate_open;
    logic       gate_closed;
    logic       busy;
    logic       fault;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    localparam int T_OUT = 20;
    localparam int N_RETRY = 3;

    gate_actuator #(
        .TIMEOUT_CYC (16'd20),
        .MAX_RETRY   (2'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .open_cmd    (open_cmd),
        .close_cmd   (close_cmd),
        .lim_open    (lim_open),
        .lim_closed  (lim_closed),
        .obstruct    (obstruct),
        .fault_clr   (fault_clr),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .gate_open   (gate_open),
        .gate_closed (gate_closed),
        .busy        (busy),
        .fault       (fault),
        .retry_cnt   (retry_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: barrier position mode, motor-on cycles, reversals, pending close
    localparam int M_CLOSED = 0;
    localparam int M_UP = 1;
    localparam int M_OPEN = 2;
    localparam int M_DOWN = 3;
    localparam int M_FAULT = 4;

    typedef struct packed {
        int mode;
        int on_cyc;
        int rev;
        int pend;
    } mdl_t;

    mdl_t m = '{mode: M_CLOSED, on_cyc: 0, rev: 0, pend: 0};

    function automatic mdl_t mstep(input mdl_t c);
        mdl_t n;
        int   want;
        n = c;
        if (c.mode != M_FAULT && lim_open && lim_closed) begin
            n.mode = M_FAULT;
        end else if (c.mode == M_CLOSED) begin
            if (open_cmd) n.mode = M_UP;
            else if (!lim_closed) n.mode = M_DOWN;
        end else if (c.mode == M_UP) begin
            if (lim_open) n.mode = M_OPEN;
            else if (c.on_cyc + 1 >= T_OUT) n.mode = M_FAULT;
        end else if (c.mode == M_OPEN) begin
            want = open_cmd ? 0 : ((close_cmd || c.pend != 0) ? 1 : 0);
            if (want == 1 && !obstruct) n.mode = M_DOWN;
            n.pend = want;
        end else if (c.mode == M_DOWN) begin
            if (lim_closed) begin
                n.mode = M_CLOSED;
                n.rev = 0;
            end else if (c.on_cyc + 1 >= T_OUT) begin
                n.mode = M_FAULT;
            end else if (open_cmd) begin
                n.mode = M_UP;
            end else if (obstruct) begin
                if (c.rev + 1 >= N_RETRY) begin
                    n.mode = M_FAULT;
                end else begin
                    n.mode = M_UP;
                    n.rev = c.rev + 1;
                end
            end
        end else if (fault_clr) begin
            n.mode = M_DOWN;
            n.rev = 0;
        end
        if (n.mode != c.mode) n.on_cyc = 0;
        else if (c.mode == M_UP || c.mode == M_DOWN) n.on_cyc = c.on_cyc + 1;
        if (n.mode != M_OPEN) n.pend = 0;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) m <= '{mode: M_CLOSED, on_cyc: 0, rev: 0, pend: 0};
        else m <= mstep(m);
    end

    function automatic logic [7:0] exp_out(input mdl_t c);
        logic [1:0] r;
        r = c.rev[1:0];
        return {c.mode == M_UP, c.mode == M_DOWN, c.mode == M_OPEN,
                c.mode == M_CLOSED, c.mode == M_UP || c.mode == M_DOWN,
                c.mode == M_FAULT, r};
    endfunction

    always @(negedge clk) begin
        logic [7:0] act;
        logic [7:0] exp;
        if (chk_en) begin
            act = {motor_up, motor_down, gate_open, gate_closed,
                   busy, fault, retry_cnt};
            exp = exp_out(m);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t outputs got %b want %b", $time, act, exp);
            end
            checks++;
            if (motor_up && motor_down) begin
                errors++;
                $display("FAIL motor_excl t=%0t both motors on", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_open();
        open_cmd = 1'b1;
        tick();
        open_cmd = 1'b0;
        lim_closed = 1'b0;
        lim_open = 1'b1;
        tick();
    endtask

    task automatic do_close();
        close_cmd = 1'b1;
        tick();
        close_cmd = 1'b0;
        lim_open = 1'b0;
    endtask

    task automatic obstruct_pulse();
        obstruct = 1'b1;
        tick();
        obstruct = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        chk("rst_closed", gate_closed, 1);
        chk("rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        open_cmd = 1'b1;
        tick();
        open_cmd = 1'b0;
        chk("open_up", motor_up, 1);
        lim_closed = 1'b0;
        repeat (3) tick();
        lim_open = 1'b1;
        tick();
        chk("open_gate", gate_open, 1);
        chk("open_up_off", motor_up, 0);

        open_cmd = 1'b1;
        close_cmd = 1'b1;
        tick();
        open_cmd = 1'b0;
        close_cmd = 1'b0;
        tick();
        chk("both_cmd_open", gate_open, 1);

        obstruct = 1'b1;
        close_cmd = 1'b1;
        tick();
        close_cmd = 1'b0;
        tick();
        chk("obst_hold_open", gate_open, 1);
        obstruct = 1'b0;
        tick();
        chk("obst_release_down", motor_down, 1);
        lim_open = 1'b0;
        tick();

        obstruct_pulse();
        chk("retry1_up", motor_up, 1);
        chk("retry1_cnt", retry_cnt, 1);
        lim_open = 1'b1;
        tick();
        do_close();
        tick();
        obstruct_pulse();
        chk("retry2_cnt", retry_cnt, 2);
        lim_open = 1'b1;
        tick();
        do_close();
        obstruct_pulse();
        chk("retry3_fault", fault, 1);
        chk("retry3_no_up", motor_up, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clr_down", motor_down, 1);
        chk("clr_retry", retry_cnt, 0);
        tick();
        lim_closed = 1'b1;
        tick();
        chk("closed_again", gate_closed, 1);

        open_cmd = 1'b1;
        tick();
        open_cmd = 1'b0;
        lim_closed = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (motor_up) n++;
            if (fault) break;
            tick();
        end
        chk("timeout_up_cycles", n, 20);
        chk("timeout_fault", fault, 1);
        chk("timeout_motors", {30'd0, motor_up, motor_down}, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("timeout_clr_down", motor_down, 1);
        repeat (3) tick();
        lim_closed = 1'b1;
        tick();

        lim_closed = 1'b0;
        tick();
        chk("drift_down", motor_down, 1);
        lim_open = 1'b1;
        lim_closed = 1'b1;
        tick();
        chk("dual_lim_fault", fault, 1);
        lim_open = 1'b0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        tick();
        chk("dual_clr_closed", gate_closed, 1);

        do_open();
        do_close();
        obstruct_pulse();
        lim_open = 1'b1;
        tick();
        do_close();
        obstruct_pulse();
        tick();
        chk("pre_rst_up", motor_up, 1);
        chk("pre_rst_retry", retry_cnt, 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_motors", {30'd0, motor_up, motor_down}, 0);
        chk("mid_rst_retry", retry_cnt, 0);
        chk("mid_rst_closed", gate_closed, 1);
        rst = 1'b0;
        tick();
        chk("post_rst_drift", motor_down, 1);
        lim_closed = 1'b1;
        tick();
        tick();
        chk("final_closed", gate_closed, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
